// File: rtl/zet_wb_master_arb_pkg.sv
// Shared state encoding, byte-lane constants and lane helpers for the Zet Wishbone master.
package zet_wb_master_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYC1,
        ST_GAP,
        ST_CYC2,
        ST_DONE
    } state_e;

    localparam logic [1:0] SEL_LO = 2'b01;
    localparam logic [1:0] SEL_HI = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b11;

    // Lane select for the first (or only) bus cycle of an access.
    function automatic logic [1:0] first_sel(input logic byte_acc, input logic a0);
        if (a0) begin
            return SEL_HI;
        end
        return byte_acc ? SEL_LO : SEL_W;
    endfunction

    // Write data for the first bus cycle; an odd address always lands its low byte on the high lane.
    function automatic logic [15:0] first_dat(input logic byte_acc, input logic a0,
                                              input logic [15:0] d);
        if (a0) begin
            return {d[7:0], 8'h00};
        end
        return byte_acc ? {8'h00, d[7:0]} : d;
    endfunction

endpackage

// File: rtl/zet_wb_master_arb_arbiter.sv
// Combinational one-hot arbiter: fixed priority (RR = 0) or round robin from a start pointer.
module zet_wb_master_arb_arbiter #(
    parameter int NCH = 2,
    parameter int RR  = 0,
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [IW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o
);

    int start;
    int idx;

    // Scan offsets from farthest to nearest so the requester closest to the start point wins.
    always_comb begin
        gnt_o = '0;
        start = (RR != 0) ? int'(ptr_i) : 0;
        idx   = 0;
        for (int i = NCH - 1; i >= 0; i--) begin
            idx = (start + i) % NCH;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zet_wb_master_arb.sv
// Wishbone master front-end: arbitrates NCH requesters onto one 16-bit bus,
// splits odd word accesses into two byte-lane cycles, optional ack timeout.
//
// state   | meaning
// IDLE    | waiting for a request; arbitration happens only here
// CYC1    | first (or only) bus cycle, strobe high until ack or timeout
// GAP     | strobe low for one cycle between the halves of a split access
// CYC2    | second half of a split word access
// DONE    | one-cycle ack (and err on timeout) to the granted channel
module zet_wb_master_arb
    import zet_wb_master_arb_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int AW      = 20,
    parameter int RR      = 0,
    parameter int TIMEOUT = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    req_stb_i,
    input  logic [NCH*AW-1:0] req_adr_i,
    input  logic [NCH*16-1:0] req_dat_i,
    input  logic [NCH-1:0]    req_we_i,
    input  logic [NCH-1:0]    req_mio_i,
    input  logic [NCH-1:0]    req_byte_i,
    output logic [NCH-1:0]    req_ack_o,
    output logic [15:0]       req_dat_o,
    output logic              err_o,
    output logic [AW-1:0]     adr_o,
    output logic [1:0]        sel_o,
    output logic [15:0]       dat_o,
    input  logic [15:0]       dat_i,
    output logic              we_o,
    output logic              mio_o,
    output logic              stb_o,
    output logic              cyc_o,
    input  logic              ack_i
);

    localparam int         IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [NCH-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [AW-1:0]   r_adr_q, r_adr_d;
    logic [7:0]      r_dhi_q, r_dhi_d;
    logic            r_byte_q, r_byte_d;
    logic [7:0]      tmo_q, tmo_d;
    logic [7:0]      lo_q, lo_d;
    logic [AW-1:0]   adr_q, adr_d;
    logic [1:0]      sel_q, sel_d;
    logic [15:0]     dat_q, dat_d;
    logic            we_q, we_d;
    logic            mio_q, mio_d;
    logic            stb_q, stb_d;
    logic [NCH-1:0]  ack_q, ack_d;
    logic [15:0]     rdat_q, rdat_d;
    logic            err_q, err_d;

    logic [NCH-1:0]  arb_gnt;
    logic [AW-1:0]   s_adr;
    logic [15:0]     s_dat;
    logic            s_we, s_mio, s_byte;
    logic [IW-1:0]   gidx;
    logic            split;
    logic [AW-1:0]   adr_inc;
    logic [15:0]     rd_result;

    zet_wb_master_arb_arbiter #(
        .NCH (NCH),
        .RR  (RR)
    ) u_arb (
        .req_i (req_stb_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    assign split   = ~r_byte_q & r_adr_q[0];
    assign adr_inc = r_adr_q + AW'(1);
    assign rd_result = (state_q == ST_CYC2) ? {dat_i[7:0], lo_q} :
                       !r_byte_q             ? dat_i :
                       r_adr_q[0]            ? {8'h00, dat_i[15:8]} :
                                               {8'h00, dat_i[7:0]};

    // Select the winning channel's request fields and its index.
    always_comb begin
        s_adr  = '0;
        s_dat  = '0;
        s_we   = 1'b0;
        s_mio  = 1'b0;
        s_byte = 1'b0;
        gidx   = '0;
        for (int n = 0; n < NCH; n++) begin
            if (arb_gnt[n]) begin
                s_adr  = req_adr_i[n*AW +: AW];
                s_dat  = req_dat_i[n*16 +: 16];
                s_we   = req_we_i[n];
                s_mio  = req_mio_i[n];
                s_byte = req_byte_i[n];
                gidx   = IW'(n);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        ptr_d    = ptr_q;
        r_adr_d  = r_adr_q;
        r_dhi_d  = r_dhi_q;
        r_byte_d = r_byte_q;
        tmo_d    = tmo_q;
        lo_d     = lo_q;
        adr_d    = adr_q;
        sel_d    = sel_q;
        dat_d    = dat_q;
        we_d     = we_q;
        mio_d    = mio_q;
        stb_d    = stb_q;
        ack_d    = '0;
        rdat_d   = rdat_q;
        err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|req_stb_i) begin
                    state_d  = ST_CYC1;
                    gnt_d    = arb_gnt;
                    ptr_d    = (int'(gidx) == NCH - 1) ? '0 : gidx + IW'(1);
                    r_adr_d  = s_adr;
                    r_dhi_d  = s_dat[15:8];
                    r_byte_d = s_byte;
                    adr_d    = {s_adr[AW-1:1], 1'b0};
                    sel_d    = first_sel(s_byte, s_adr[0]);
                    dat_d    = first_dat(s_byte, s_adr[0], s_dat);
                    we_d     = s_we;
                    mio_d    = s_mio;
                    stb_d    = 1'b1;
                    tmo_d    = '0;
                end
            end
            ST_CYC1, ST_CYC2: begin
                if (ack_i) begin
                    stb_d = 1'b0;
                    sel_d = '0;
                    if (state_q == ST_CYC1 && split) begin
                        lo_d    = dat_i[15:8];
                        state_d = ST_GAP;
                    end else begin
                        we_d    = 1'b0;
                        ack_d   = gnt_q;
                        rdat_d  = rd_result;
                        state_d = ST_DONE;
                    end
                end else if (TIMEOUT > 0 && tmo_q == TMO_LAST) begin
                    stb_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    ack_d   = gnt_q;
                    err_d   = 1'b1;
                    rdat_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_GAP: begin
                adr_d   = {adr_inc[AW-1:1], 1'b0};
                sel_d   = SEL_LO;
                dat_d   = {8'h00, r_dhi_q};
                stb_d   = 1'b1;
                tmo_d   = '0;
                state_d = ST_CYC2;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            ptr_q    <= '0;
            r_adr_q  <= '0;
            r_dhi_q  <= '0;
            r_byte_q <= 1'b0;
            tmo_q    <= '0;
            lo_q     <= '0;
            adr_q    <= '0;
            sel_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            mio_q    <= 1'b0;
            stb_q    <= 1'b0;
            ack_q    <= '0;
            rdat_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            r_adr_q  <= r_adr_d;
            r_dhi_q  <= r_dhi_d;
            r_byte_q <= r_byte_d;
            tmo_q    <= tmo_d;
            lo_q     <= lo_d;
            adr_q    <= adr_d;
            sel_q    <= sel_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            mio_q    <= mio_d;
            stb_q    <= stb_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            err_q    <= err_d;
        end
    end

    assign adr_o     = adr_q;
    assign sel_o     = sel_q;
    assign dat_o     = dat_q;
    assign we_o      = we_q;
    assign mio_o     = mio_q;
    assign stb_o     = stb_q;
    assign cyc_o     = stb_q;
    assign req_ack_o = ack_q;
    assign req_dat_o = rdat_q;
    assign err_o     = err_q;

endmodule
